// File: rtl/pla_drv_pkg.sv
// Shared types and constants for the PLA vector driver.
// Holds the FSM encoding, LFSR tap masks and the MISR polynomial.
package pla_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } drv_state_e;

  // taps 24,23,22,17 as bit positions 23,22,21,16
  localparam logic [23:0] LFSR_TAPS_24 = 24'hE1_0000;

  localparam logic [15:0] MISR_POLY = 16'h1021;

  // Maximal-length tap masks for shift-left Fibonacci LFSRs
  function automatic logic [31:0] lfsr_taps(input int unsigned n);
    logic [31:0] t;
    case (n)
      4:       t = 32'h0000_000C;
      8:       t = 32'h0000_00B8;
      16:      t = 32'h0000_D008;
      default: t = {8'h00, LFSR_TAPS_24};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pla_lfsr.sv
// Fibonacci LFSR used as the pseudo-random vector source.
// Shifts left; feedback is the XOR of the tapped state bits.
module pla_lfsr
  import pla_drv_pkg::*;
#(
  parameter int              N_IN    = 24,
  parameter logic [N_IN-1:0] RST_VAL = N_IN'(1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [N_IN-1:0] seed_i,
  output logic [N_IN-1:0] state_o,
  output logic [N_IN-1:0] next_o
);

  localparam logic [N_IN-1:0] TAPS = N_IN'(lfsr_taps(N_IN));

  logic [N_IN-1:0] state_q;
  logic [N_IN-1:0] state_d;

  assign next_o  = {state_q[N_IN-2:0], ^(state_q & TAPS)};
  assign state_o = state_q;

  // load has priority over step
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = next_o;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_VAL;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/pla_vector_driver.sv
// Drives vectors into a PLA core and accumulates its onset count.
// Optional MISR signature enabled by defining PLA_DRV_MISR_EN.
module pla_vector_driver
  import pla_drv_pkg::*;
#(
  parameter int              N_IN      = 24,
  parameter int              CNT_W     = N_IN + 1,
  parameter int              SIG_W     = 16,
  parameter logic [N_IN-1:0] LFSR_SEED = N_IN'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] num_vec,
  output logic [N_IN-1:0]  x_o,
  input  logic             y_i,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] onset_cnt,
  output logic [SIG_W-1:0] sig
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXH_N   = ONE << N_IN;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  drv_state_e       state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] nv_q, nv_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic             smp_q, smp_d;
  logic             y_q, y_d;
  logic [CNT_W-1:0] onset_q, onset_d;

  logic             start_acc;
  logic             lfsr_load;
  logic             lfsr_step;
  logic [N_IN-1:0]  lfsr_state;
  logic [N_IN-1:0]  lfsr_next;

  assign start_acc = start && (state_q == IDLE);

  pla_lfsr #(
    .N_IN    (N_IN),
    .RST_VAL (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (LFSR_SEED),
    .state_o (lfsr_state),
    .next_o  (lfsr_next)
  );

  // FSM, vector issue and onset accumulation
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    nv_d      = nv_q;
    vec_d     = vec_q;
    x_d       = x_q;
    smp_d     = (state_q == DRIVE);
    y_d       = y_i;
    onset_d   = onset_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    if (smp_q && y_q && (onset_q != CNT_MAX)) begin
      onset_d = onset_q + ONE;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          nv_d    = mode ? num_vec : EXH_N;
          onset_d = '0;
          if (mode && (num_vec == '0)) begin
            state_d = DRAIN;
            vec_d   = '0;
          end else begin
            state_d   = DRIVE;
            vec_d     = ONE;
            x_d       = mode ? LFSR_SEED : '0;
            lfsr_load = mode;
          end
        end
      end
      DRIVE: begin
        if (vec_q >= nv_q) begin
          state_d = DRAIN;
        end else begin
          x_d       = mode_q ? lfsr_next : x_q + N_IN'(1);
          lfsr_step = mode_q;
          vec_d     = (vec_q == CNT_MAX) ? vec_q : vec_q + ONE;
        end
      end
      DRAIN: begin
        state_d = REPORT;
      end
      REPORT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      nv_q    <= '0;
      vec_q   <= '0;
      x_q     <= '0;
      smp_q   <= 1'b0;
      y_q     <= 1'b0;
      onset_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      nv_q    <= nv_d;
      vec_q   <= vec_d;
      x_q     <= x_d;
      smp_q   <= smp_d;
      y_q     <= y_d;
      onset_q <= onset_d;
    end
  end

`ifdef PLA_DRV_MISR_EN
  localparam logic [SIG_W-1:0] POLY = SIG_W'(MISR_POLY);

  logic [SIG_W-1:0] sig_q, sig_d;

  // MISR folds each sample into the signature
  always_comb begin
    sig_d = sig_q;
    if (start_acc) begin
      sig_d = '0;
    end else if (smp_q) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0}
            ^ (sig_q[SIG_W-1] ? POLY : '0)
            ^ {{(SIG_W-1){1'b0}}, y_q};
    end
  end

  // signature register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`else
  assign sig = '0;
`endif

  assign x_o       = x_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == REPORT);
  assign onset_cnt = onset_q;

endmodule
